// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop framing with a
// one-word holding register, valid/ready handoff and sticky overrun flag.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun_err,
   input  logic       err_clr,
   output logic       busy
);

   // state  | meaning
   // IDLE   | line idle, waiting for a low sample on a tick
   // START  | start bit seen, confirming it at mid-bit
   // DATA   | shifting in DATA_BITS data bits, LSB first
   // PARITY | sampling the parity bit
   // STOP   | sampling STOP_BITS stop bits; frame completes on the last one
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       PAR_ODD   = (PARITY_ODD != 0);
   localparam logic       PAR_EN    = (PARITY_EN != 0);

   state_t     state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic       rxd_meta;
   logic       rxd_s;
   logic [7:0] shift_reg;
   logic       par_err_acc;
   logic       frm_err_acc;
   logic       bit_tick;
   logic       frame_done;
   logic       frame_ferr;

   assign bit_tick   = sample_tick && (tick_cnt == 4'd15);
   assign frame_done = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);
   assign frame_ferr = frm_err_acc | ~rxd_s;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tick_cnt    <= 4'd0;
         bit_cnt     <= 3'd0;
         shift_reg   <= 8'd0;
         par_err_acc <= 1'b0;
         frm_err_acc <= 1'b0;
      end else if (sample_tick) begin
         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state    <= START;
                  tick_cnt <= 4'd0;
               end
            end
            START: begin
               if (tick_cnt == 4'd7) begin
                  tick_cnt <= 4'd0;
                  bit_cnt  <= 3'd0;
                  if (!rxd_s) begin
                     state       <= DATA;
                     shift_reg   <= 8'd0;
                     par_err_acc <= 1'b0;
                     frm_err_acc <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
            DATA: begin
               tick_cnt <= tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  shift_reg[bit_cnt] <= rxd_s;
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= 3'd0;
                     state   <= PAR_EN ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            PARITY: begin
               tick_cnt <= tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  // upper unused bits of shift_reg are zero, so they do not disturb the XOR
                  par_err_acc <= ((^shift_reg) ^ rxd_s) != PAR_ODD;
                  state       <= STOP;
               end
            end
            STOP: begin
               tick_cnt <= tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  if (!rxd_s) frm_err_acc <= 1'b1;
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= 3'd0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data     <= 8'd0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         // a new overrun wins over a simultaneous clear
         if (frame_done && rx_valid && !rx_ready) overrun_err <= 1'b1;
         else if (err_clr)                        overrun_err <= 1'b0;

         if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data    <= shift_reg;
            parity_err <= par_err_acc;
            frame_err  <= frame_ferr;
            rx_valid   <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8N1 instance plus an even-parity
// instance, each with its own serial line and shared control inputs.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       rxd_a = 1'b1;
   logic       rxd_b = 1'b1;
   logic       rx_ready = 1'b1;
   logic       err_clr = 1'b0;

   logic [7:0] rx_data_a, rx_data_b;
   logic       rx_valid_a, rx_valid_b;
   logic       parity_err_a, parity_err_b;
   logic       frame_err_a, frame_err_b;
   logic       overrun_err_a, overrun_err_b;
   logic       busy_a, busy_b;

   int         n_cmp = 0;
   int         n_mis = 0;

   logic [9:0] cap_q[$];
   int         valid_cycles_a = 0;
   logic       busy_seen_a = 1'b0;
   logic [9:0] last_b = '0;
   int         cnt_b = 0;

   uart_rx u_dut_a (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
      .parity_err(parity_err_a), .frame_err(frame_err_a),
      .overrun_err(overrun_err_a), .err_clr(err_clr), .busy(busy_a)
   );

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_b (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
      .parity_err(parity_err_b), .frame_err(frame_err_b),
      .overrun_err(overrun_err_b), .err_clr(err_clr), .busy(busy_b)
   );

   always #5 clk = ~clk;

   // one tick every 4 clocks, changed just after the rising edge
   initial begin
      int div = 0;
      forever begin
         @(posedge clk);
         #1;
         div = (div + 1) % 4;
         sample_tick = (div == 0);
      end
   end

   always @(negedge clk) begin
      if (rx_valid_a) valid_cycles_a++;
      if (busy_a) busy_seen_a = 1'b1;
      if (rx_valid_a && rx_ready) cap_q.push_back({frame_err_a, parity_err_a, rx_data_a});
      if (rx_valid_b && rx_ready) begin
         last_b = {frame_err_b, parity_err_b, rx_data_b};
         cnt_b++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(negedge clk);
         while (!sample_tick) @(negedge clk);
      end
   endtask

   task automatic drive_bit(input bit sel, input bit v, input int ticks);
      @(posedge clk);
      #2;
      if (sel) rxd_b = v;
      else     rxd_a = v;
      wait_ticks(ticks);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] data, input bit has_par,
                             input bit par, input bit stop_v);
      drive_bit(sel, 1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(sel, data[i], 16);
      if (has_par) drive_bit(sel, par, 16);
      if (stop_v) begin
         drive_bit(sel, 1'b1, 16);
      end else begin
         drive_bit(sel, 1'b0, 12);
         drive_bit(sel, 1'b1, 16);
      end
   endtask

   task automatic set_ctrl(input logic rdy, input logic clr);
      @(posedge clk);
      #2;
      rx_ready = rdy;
      err_clr  = clr;
   endtask

   initial begin
      logic [9:0] ent;
      int         base;

      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_valid_a", rx_valid_a, 0);
      check_val("rst_data_a", rx_data_a, 8'h00);
      check_val("rst_flags_a", {parity_err_a, frame_err_a, overrun_err_a}, 3'b000);
      check_val("rst_busy_a", busy_a, 0);
      check_val("rst_busy_b", busy_b, 0);
      check_val("rst_ovr_b", overrun_err_b, 0);
      wait_ticks(8);

      // clean 0xA5 frame with consumer always ready
      valid_cycles_a = 0;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      check_val("a5_count", cap_q.size(), 1);
      ent = cap_q[0];
      check_val("a5_data", ent[7:0], 8'hA5);
      check_val("a5_flags", ent[9:8], 2'b00);
      check_val("a5_valid_cycles", valid_cycles_a, 1);
      check_val("a5_valid_now", rx_valid_a, 0);

      // 4-tick low glitch is rejected
      busy_seen_a = 1'b0;
      base = cap_q.size();
      drive_bit(1'b0, 1'b0, 4);
      drive_bit(1'b0, 1'b1, 24);
      check_val("glitch_busy_seen", busy_seen_a, 1);
      check_val("glitch_no_output", cap_q.size(), base);
      check_val("glitch_idle", busy_a, 0);

      // even parity: 0x07 with parity bit 0 is wrong, with 1 is right
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      check_val("par_bad_count", cnt_b, 1);
      check_val("par_bad_data", last_b[7:0], 8'h07);
      check_val("par_bad_perr", last_b[8], 1);
      check_val("par_bad_ferr", last_b[9], 0);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      check_val("par_ok_count", cnt_b, 2);
      check_val("par_ok_perr", last_b[8], 0);

      // stop bit low
      base = cap_q.size();
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b1, 24);
      check_val("ferr_count", cap_q.size(), base + 1);
      ent = cap_q[base];
      check_val("ferr_data", ent[7:0], 8'h3C);
      check_val("ferr_flag", ent[9], 1);
      check_val("ferr_perr", ent[8], 0);

      // overrun while consumer stalls
      base = cap_q.size();
      set_ctrl(1'b0, 1'b0);
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      check_val("ovr_first_valid", rx_valid_a, 1);
      check_val("ovr_first_data", rx_data_a, 8'h11);
      check_val("ovr_first_flag", overrun_err_a, 0);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      check_val("ovr_held_data", rx_data_a, 8'h11);
      check_val("ovr_held_valid", rx_valid_a, 1);
      check_val("ovr_flag", overrun_err_a, 1);
      set_ctrl(1'b0, 1'b1);
      set_ctrl(1'b0, 1'b0);
      @(negedge clk);
      check_val("ovr_cleared", overrun_err_a, 0);
      check_val("ovr_still_valid", rx_valid_a, 1);
      set_ctrl(1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check_val("ovr_drained_valid", rx_valid_a, 0);
      check_val("ovr_drained_count", cap_q.size(), base + 1);
      ent = cap_q[base];
      check_val("ovr_drained_data", ent[7:0], 8'h11);

      // back-to-back frames
      base = cap_q.size();
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
      check_val("b2b_count", cap_q.size(), base + 2);
      ent = cap_q[base];
      check_val("b2b_first", ent[7:0], 8'h5A);
      ent = cap_q[base + 1];
      check_val("b2b_second", ent[7:0], 8'hC3);

      // reset in the middle of the 0x55 data bits
      base = cap_q.size();
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b1, 16);
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b1, 8);
      check_val("mid_busy_before_rst", busy_a, 1);
      @(posedge clk);
      #2;
      rst   = 1'b1;
      rxd_a = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_rst_busy", busy_a, 0);
      check_val("mid_rst_valid", rx_valid_a, 0);
      check_val("mid_rst_data", rx_data_a, 8'h00);
      drive_bit(1'b0, 1'b1, 24);
      check_val("mid_rst_no_output", cap_q.size(), base);
      send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
      check_val("post_rst_count", cap_q.size(), base + 1);
      ent = cap_q[base];
      check_val("post_rst_data", ent[7:0], 8'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
